// File: rtl/uart_alu_pkg.sv
// Shared types and helpers for the framed UART/ALU bridge.
// Build option: CHKSUM_EN adds a trailing checksum byte to each frame.
package uart_alu_pkg;

  localparam logic [2:0] RX_A   = 3'd0;
  localparam logic [2:0] RX_B   = 3'd1;
  localparam logic [2:0] RX_OP  = 3'd2;
  localparam logic [2:0] RX_CHK = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] TX     = 3'd6;
  localparam logic [2:0] TX_ERR = 3'd7;

  localparam logic [7:0] ERR_CODE = 8'hEE;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Counter/index width that still works when only one value is needed.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_alu_frame_if_if.sv
// UART RX/TX FIFO handshake bundle; master is the bridge, slave is the FIFO pair.
interface uart_alu_frame_if_if;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;

  modport master (output rd_uart, wr_uart, w_data, input r_data, rx_empty, tx_full);
  modport slave  (input rd_uart, wr_uart, w_data, output r_data, rx_empty, tx_full);
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter; expire flags TIMEOUT_CYC-1 idle cycles unless a clear arrives.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable && cnt != LAST) cnt <= cnt + 1'b1;
  end

  // A pop in the expiry cycle wins, so clear masks expire.
  assign expire = enable && !clear && (cnt == LAST);
endmodule

// File: rtl/uart_alu_frame_if.sv
// Framed UART/ALU bridge: RX A, B, op (LSB first), commit atomically, stream result back.
// Build option: CHKSUM_EN expects an XOR checksum byte after the opcode.
//
// state  | meaning
// RX_A   | collect operand A bytes into shadow
// RX_B   | collect operand B bytes into shadow
// RX_OP  | collect opcode byte
// RX_CHK | check frame XOR (CHKSUM_EN only)
// COMMIT | load a/b/op from shadows in one cycle
// WAIT   | ALU latency, latch result on the last cycle
// TX     | push result bytes, LSB first
// TX_ERR | push ERR_CODE after a bad checksum (CHKSUM_EN only)
module uart_alu_frame_if
  import uart_alu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 8,
  parameter int ALU_LAT     = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_alu_frame_if_if.master      uart,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic [OP_W-1:0]          op,
  input  logic signed [DATA_W-1:0] w,
  output logic                     busy
);
  localparam int NBYTES = nbytes(DATA_W);
  localparam int IDX_W  = idx_w(NBYTES);
  localparam int WAIT_W = idx_w(ALU_LAT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LAT - 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] shadow_a, shadow_b, result;
  logic [OP_W-1:0]   shadow_op;
  logic              in_rx, pop, expire;
`ifdef CHKSUM_EN
  logic [7:0]        chk;
`endif

  always_comb begin
    in_rx = (state == RX_A) || (state == RX_B) || (state == RX_OP) || (state == RX_CHK);
    uart.rd_uart = in_rx && !uart.rx_empty;
    uart.wr_uart = 1'b0;
    uart.w_data  = 8'h00;
    if (state == TX) begin
      uart.wr_uart = !uart.tx_full;
      uart.w_data  = result[8*idx +: 8];
    end
`ifdef CHKSUM_EN
    else if (state == TX_ERR) begin
      uart.wr_uart = !uart.tx_full;
      uart.w_data  = ERR_CODE;
    end
`endif
  end

  assign pop = uart.rd_uart;

  // busy doubles as "frame started": the timer only runs once a byte is in.
  uart_byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (pop || !busy),
    .enable (in_rx && busy),
    .expire (expire)
  );

`ifdef CHKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) chk <= 8'h00;
    else if (pop) chk <= (state == RX_A && idx == '0) ? uart.r_data : (chk ^ uart.r_data);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_A;
      idx       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_op <= '0;
      result    <= '0;
    end else if (expire) begin
      state     <= RX_A;
      idx       <= '0;
      busy      <= 1'b0;
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_op <= '0;
    end else begin
      case (state)
        RX_A: if (pop) begin
          busy <= 1'b1;
          shadow_a[8*idx +: 8] <= uart.r_data;
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          if (idx == LAST_IDX) state <= RX_B;
        end
        RX_B: if (pop) begin
          shadow_b[8*idx +: 8] <= uart.r_data;
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          if (idx == LAST_IDX) state <= RX_OP;
        end
        RX_OP: if (pop) begin
          shadow_op <= uart.r_data[OP_W-1:0];
`ifdef CHKSUM_EN
          state <= RX_CHK;
`else
          state <= COMMIT;
`endif
        end
`ifdef CHKSUM_EN
        RX_CHK: if (pop) state <= (uart.r_data == chk) ? COMMIT : TX_ERR;
        TX_ERR: if (uart.wr_uart) begin
          busy  <= 1'b0;
          state <= RX_A;
        end
`endif
        COMMIT: begin
          a        <= shadow_a;
          b        <= shadow_b;
          op       <= shadow_op;
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            result <= w;
            state  <= TX;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        TX: if (uart.wr_uart) begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            busy  <= 1'b0;
            state <= RX_A;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= RX_A;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Scoreboard bench for uart_alu_frame_if (DATA_W=16); covers CHKSUM_EN when that macro is defined.
module tb_uart_alu_frame_if;
  import uart_alu_pkg::*;

  localparam int DATA_W = 16, OP_W = 2, ALU_LAT = 1, TIMEOUT_CYC = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_alu_frame_if_if uart ();
  logic signed [DATA_W-1:0] a, b, w;
  logic [OP_W-1:0] op;
  logic busy;

  uart_alu_frame_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(ALU_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .uart(uart), .a(a), .b(b), .op(op), .w(w), .busy(busy)
  );

  // Reference ALU: 0 add, 1 sub, otherwise xor
  always_comb begin
    case (op)
      2'd0:    w = a + b;
      2'd1:    w = a - b;
      default: w = a ^ b;
    endcase
  end

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit gap_en = 1'b0, gap = 1'b0, pop_pending = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RX FIFO model: inputs change only 1 time unit after the rising edge
  initial begin
    uart.rx_empty = 1'b1;
    uart.r_data   = 8'h00;
    uart.tx_full  = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
    gap = gap_en ? ~gap : 1'b0;
    uart.rx_empty = (rx_q.size() == 0) || gap;
    uart.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Monitor: RX handshake legality and TX scoreboard
  always @(negedge clk) begin
    pop_pending = uart.rd_uart;
    if (!reset) begin
      if (uart.rd_uart) check("rd_only_when_data", {15'd0, uart.rx_empty}, 16'd0);
      if (uart.wr_uart) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_push actual=%h required=none", uart.w_data);
        end else begin
          check("tx_byte", {8'd0, uart.w_data}, {8'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_frame(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] opb);
    rx_q.push_back(av[7:0]);
    rx_q.push_back(av[15:8]);
    rx_q.push_back(bv[7:0]);
    rx_q.push_back(bv[15:8]);
    rx_q.push_back(opb);
`ifdef CHKSUM_EN
    rx_q.push_back(av[7:0] ^ av[15:8] ^ bv[7:0] ^ bv[15:8] ^ opb);
`endif
  endtask

  task automatic expect_res(input logic [15:0] r);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_assert++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_drain actual=%0d_bytes_left required=0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, a, 16'h0000);
    check({tag, "_b"}, b, 16'h0000);
    check({tag, "_op"}, {14'd0, op}, 16'h0000);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_wr_uart"}, {15'd0, uart.wr_uart}, 16'd0);
    check({tag, "_w_data"}, {8'd0, uart.w_data}, 16'd0);
    check({tag, "_rd_uart"}, {15'd0, uart.rd_uart}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    check_reset_values("reset");
    reset = 1'b0;

    // Basic frame: 0x1234 + 0x0010
    expect_res(16'h1244);
    send_frame(16'h1234, 16'h0010, 8'h00);
    wait_drain("basic", 100);
    check("basic_a", a, 16'h1234);
    check("basic_b", b, 16'h0010);
    check("basic_op", {14'd0, op}, 16'd0);
    check("basic_busy", {15'd0, busy}, 16'd0);

    // Establish a=5, then a partial frame must time out without touching a/b/op
    expect_res(16'h0002);
    send_frame(16'h0005, 16'h0003, 8'h01);
    wait_drain("prior", 100);
    check("prior_a", a, 16'h0005);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    cycles(10);
    check("partial_a_held", a, 16'h0005);
    check("partial_busy", {15'd0, busy}, 16'd1);
    cycles(TIMEOUT_CYC + 5);
    check("timeout_busy", {15'd0, busy}, 16'd0);
    check("timeout_a_held", a, 16'h0005);
    check("timeout_b_held", b, 16'h0003);
    expect_res(16'h0FF0);
    send_frame(16'h00FF, 16'h0F0F, 8'h02);
    wait_drain("recover", 100);
    check("recover_a", a, 16'h00FF);

    // Back-pressure in TX
    uart.tx_full = 1'b1;
    expect_res(16'h0030);
    send_frame(16'h0010, 16'h0020, 8'h00);
    cycles(20);
    for (int i = 0; i < 50; i++) begin
      check("bp_no_push", {15'd0, uart.wr_uart}, 16'd0);
      check("bp_w_data_stable", {8'd0, uart.w_data}, 16'h0030);
      cycles(1);
    end
    uart.tx_full = 1'b0;
    wait_drain("bp", 100);

    // RX gaps: same result as back-to-back
    gap_en = 1'b1;
    expect_res(16'h1244);
    send_frame(16'h1234, 16'h0010, 8'h00);
    wait_drain("gaps", 200);
    gap_en = 1'b0;
    check("gaps_a", a, 16'h1234);

    // Reset after the first result byte: second byte must never appear
    uart.tx_full = 1'b1;
    exp_q.push_back(8'h02);
    send_frame(16'h0001, 16'h0001, 8'h00);
    cycles(15);
    uart.tx_full = 1'b0;
    cycles(1);
    uart.tx_full = 1'b1;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check_reset_values("midtx");
    uart.tx_full = 1'b0;
    cycles(20);
    check("midtx_pushes_left", 16'(exp_q.size()), 16'd0);

    // Upper opcode bits ignored: 0x81 -> sub
    expect_res(16'h000F);
    send_frame(16'h0010, 16'h0001, 8'h81);
    wait_drain("after_reset", 100);
    check("opmask_op", {14'd0, op}, 16'd1);

`ifdef CHKSUM_EN
    // Bad checksum: single ERR_CODE, no commit
    exp_q.push_back(ERR_CODE);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h04);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    wait_drain("chk_bad", 100);
    check("chk_bad_a", a, 16'h0010);
    check("chk_bad_op", {14'd0, op}, 16'd1);
    expect_res(16'h0007);
    send_frame(16'h0003, 16'h0004, 8'h00);
    wait_drain("chk_good", 100);
`endif

    cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
